// File: rtl/results_layout_pkg.sv
// Results RAM layout and FSM encoding.
// Both the results writer and the results sender use this package.
package results_layout_pkg;

  localparam int unsigned NUMBER_OF_T_ADDRESS   = 1;
  localparam int unsigned NUMBER_OF_X_ADDRESS   = 2;
  localparam int unsigned STARTING_OF_T_ADDRESS = 3;
  localparam int unsigned STARTING_OF_X_ADDRESS = 10;
  localparam int unsigned MAX_T                 = 7;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    HDR_T,
    HDR_X,
    SEND,
    ERR
  } rw_state_e;

endpackage

// File: rtl/results_addr_gen.sv
// T/X write pointers, X index, T count and overflow flags.
// The X pointer runs as a counter, so no multiplier is needed.
module results_addr_gen
  import results_layout_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init,
  input  logic                     acc_t,
  input  logic                     acc_x,
  input  logic [DATA_WIDTH-1:0]    num_x,
  output logic [ADDRESS_WIDTH-1:0] t_addr,
  output logic [ADDRESS_WIDTH-1:0] x_addr,
  output logic [2:0]               num_t,
  output logic                     expect_t,
  output logic                     t_full,
  output logic                     x_ovf
);

  logic [ADDRESS_WIDTH-1:0] t_ptr_q, t_ptr_d;
  logic [ADDRESS_WIDTH:0]   x_ptr_q, x_ptr_d;
  logic [DATA_WIDTH-1:0]    x_idx_q, x_idx_d;
  logic [2:0]               num_t_q, num_t_d;
  logic                     exp_t_q, exp_t_d;

  always_comb begin
    t_ptr_d = t_ptr_q;
    x_ptr_d = x_ptr_q;
    x_idx_d = x_idx_q;
    num_t_d = num_t_q;
    exp_t_d = exp_t_q;
    if (init) begin
      t_ptr_d = ADDRESS_WIDTH'(STARTING_OF_T_ADDRESS);
      x_ptr_d = (ADDRESS_WIDTH+1)'(STARTING_OF_X_ADDRESS);
      x_idx_d = '0;
      num_t_d = '0;
      exp_t_d = 1'b1;
    end else if (acc_t) begin
      t_ptr_d = t_ptr_q + 1'b1;
      num_t_d = num_t_q + 1'b1;
      x_idx_d = '0;
      exp_t_d = 1'b0;
    end else if (acc_x) begin
      x_ptr_d = x_ptr_q + 1'b1;
      if (x_idx_q == num_x - DATA_WIDTH'(1)) begin
        x_idx_d = '0;
        exp_t_d = 1'b1;
      end else begin
        x_idx_d = x_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_ptr_q <= '0;
      x_ptr_q <= '0;
      x_idx_q <= '0;
      num_t_q <= '0;
      exp_t_q <= 1'b0;
    end else begin
      t_ptr_q <= t_ptr_d;
      x_ptr_q <= x_ptr_d;
      x_idx_q <= x_idx_d;
      num_t_q <= num_t_d;
      exp_t_q <= exp_t_d;
    end
  end

  assign t_addr   = t_ptr_q;
  assign x_addr   = x_ptr_q[ADDRESS_WIDTH-1:0];
  assign num_t    = num_t_q;
  assign expect_t = exp_t_q;
  assign t_full   = (num_t_q == 3'(MAX_T));
  // Bit ADDRESS_WIDTH is set once the pointer has run past the last RAM word.
  assign x_ovf    = x_ptr_q[ADDRESS_WIDTH];

endmodule

// File: rtl/results_writer.sv
// Collects T/X solver samples into RAM, then writes the header words
// and hands off to the results sender.
module results_writer
  import results_layout_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     Start,
  input  logic [DATA_WIDTH-1:0]    Num_X,
  input  logic                     Sample_Valid,
  output logic                     Sample_Ready,
  input  logic                     Sample_Is_T,
  input  logic [DATA_WIDTH-1:0]    Sample_Data,
  input  logic                     Finish,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  output logic [DATA_WIDTH-1:0]    RAM_Data,
  output logic                     RAM_Write_Enable,
  output logic                     Sending_Enable,
  input  logic                     Done_Sending,
  output logic                     Busy,
  output logic                     Error
);

  rw_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0]    num_x_q, num_x_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     we_q, we_d;
  logic                     send_q, busy_q, err_q;

  logic [ADDRESS_WIDTH-1:0] t_addr, x_addr;
  logic [2:0]               num_t;
  logic                     expect_t, t_full, x_ovf;
  logic                     init, fire, acc_t, acc_x;

  assign Sample_Ready = (state_q == COLLECT) && !Finish;
  assign fire  = Sample_Valid && Sample_Ready;
  assign acc_t = fire && expect_t && Sample_Is_T && !t_full;
  assign acc_x = fire && !expect_t && !Sample_Is_T && !x_ovf;

  results_addr_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_addr_gen (
    .clk     (CLK),
    .rst_n   (RST_N),
    .init    (init),
    .acc_t   (acc_t),
    .acc_x   (acc_x),
    .num_x   (num_x_q),
    .t_addr  (t_addr),
    .x_addr  (x_addr),
    .num_t   (num_t),
    .expect_t(expect_t),
    .t_full  (t_full),
    .x_ovf   (x_ovf)
  );

  always_comb begin
    state_d = state_q;
    num_x_d = num_x_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    init    = 1'b0;
    unique case (state_q)
      IDLE, ERR: begin
        if (Start) begin
          if (Num_X == '0) begin
            state_d = ERR;
          end else begin
            state_d = COLLECT;
            num_x_d = Num_X;
            init    = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (Finish) begin
          state_d = (expect_t && num_t != 3'd0) ? HDR_T : ERR;
        end else if (acc_t) begin
          we_d   = 1'b1;
          addr_d = t_addr;
          data_d = Sample_Data;
        end else if (acc_x) begin
          we_d   = 1'b1;
          addr_d = x_addr;
          data_d = Sample_Data;
        end else if (fire) begin
          state_d = ERR;
        end
      end
      HDR_T: begin
        we_d    = 1'b1;
        addr_d  = ADDRESS_WIDTH'(NUMBER_OF_T_ADDRESS);
        data_d  = DATA_WIDTH'(num_t);
        state_d = HDR_X;
      end
      HDR_X: begin
        we_d    = 1'b1;
        addr_d  = ADDRESS_WIDTH'(NUMBER_OF_X_ADDRESS);
        data_d  = num_x_q;
        state_d = SEND;
      end
      SEND: begin
        if (Done_Sending) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      num_x_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_x_q <= num_x_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      send_q  <= (state_d == SEND);
      busy_q  <= (state_d != IDLE) && (state_d != ERR);
      err_q   <= (state_d == ERR);
    end
  end

  assign RAM_Address      = addr_q;
  assign RAM_Data         = data_q;
  assign RAM_Write_Enable = we_q;
  assign Sending_Enable   = send_q;
  assign Busy             = busy_q;
  assign Error            = err_q;

endmodule

// File: tb/tb_results_writer.sv
// Scoreboard bench for results_writer: expected RAM writes are queued
// as stimulus is driven and matched as the DUT writes.
module tb_results_writer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Start;
  logic [63:0] Num_X;
  logic        Sample_Valid;
  logic        Sample_Ready;
  logic        Sample_Is_T;
  logic [63:0] Sample_Data;
  logic        Finish;
  logic [12:0] RAM_Address;
  logic [63:0] RAM_Data;
  logic        RAM_Write_Enable;
  logic        Sending_Enable;
  logic        Done_Sending;
  logic        Busy;
  logic        Error;

  typedef struct {
    logic [12:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  always #5 CLK = ~CLK;

  results_writer dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .Start           (Start),
    .Num_X           (Num_X),
    .Sample_Valid    (Sample_Valid),
    .Sample_Ready    (Sample_Ready),
    .Sample_Is_T     (Sample_Is_T),
    .Sample_Data     (Sample_Data),
    .Finish          (Finish),
    .RAM_Address     (RAM_Address),
    .RAM_Data        (RAM_Data),
    .RAM_Write_Enable(RAM_Write_Enable),
    .Sending_Enable  (Sending_Enable),
    .Done_Sending    (Done_Sending),
    .Busy            (Busy),
    .Error           (Error)
  );

  function automatic void push(input int a, input logic [63:0] d);
    wr_t w;
    w.addr = 13'(a);
    w.data = d;
    exp_q.push_back(w);
  endfunction

  // One clock; any write seen after the edge is matched against the queue.
  task automatic tick();
    wr_t e;
    @(posedge CLK);
    #1;
    if (RAM_Write_Enable) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected got addr=%0d data=%0h, want no write",
                 RAM_Address, RAM_Data);
      end else begin
        e = exp_q.pop_front();
        if (RAM_Address !== e.addr || RAM_Data !== e.data) begin
          fails++;
          $display("FAIL wr_match got addr=%0d data=%0h, want addr=%0d data=%0h",
                   RAM_Address, RAM_Data, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drained got %0d pending writes, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic start_run(input logic [63:0] nx);
    Start = 1'b1;
    Num_X = nx;
    tick();
    Start = 1'b0;
  endtask

  task automatic sample(input logic is_t, input logic [63:0] d);
    Sample_Valid = 1'b1;
    Sample_Is_T  = is_t;
    Sample_Data  = d;
    tick();
    Sample_Valid = 1'b0;
    Sample_Is_T  = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({Busy, Error, Sending_Enable, RAM_Write_Enable, Sample_Ready} !== 5'b0
        || RAM_Address !== 13'd0 || RAM_Data !== 64'd0) begin
      fails++;
      $display("FAIL reset_outputs got busy=%b err=%b send=%b we=%b rdy=%b addr=%0d, want all 0",
               Busy, Error, Sending_Enable, RAM_Write_Enable, Sample_Ready, RAM_Address);
    end
  endtask

  task automatic test_basic_run();
    start_run(64'd2);
    tests++;
    if (Busy !== 1'b1 || Sample_Ready !== 1'b1 || Error !== 1'b0) begin
      fails++;
      $display("FAIL basic_start got busy=%b rdy=%b err=%b, want 1 1 0",
               Busy, Sample_Ready, Error);
    end
    push(3, 64'hA0);  sample(1'b1, 64'hA0);
    push(10, 64'hB0); sample(1'b0, 64'hB0);
    push(11, 64'hB1); sample(1'b0, 64'hB1);
    // Start inside a run must not disturb it.
    start_run(64'd5);
    push(4, 64'hA1);  sample(1'b1, 64'hA1);
    push(12, 64'hC0); sample(1'b0, 64'hC0);
    push(13, 64'hC1); sample(1'b0, 64'hC1);
    push(1, 64'd2);
    push(2, 64'd2);
    Finish = 1'b1;
    tick();
    Finish = 1'b0;
    tick();
    tests++;
    if (Sending_Enable !== 1'b0) begin
      fails++;
      $display("FAIL basic_send_early got %b, want 0", Sending_Enable);
    end
    tick();
    tests++;
    if (Sending_Enable !== 1'b1 || Busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_send got send=%b busy=%b, want 1 1", Sending_Enable, Busy);
    end
    tick();
    tests++;
    if (Sending_Enable !== 1'b1) begin
      fails++;
      $display("FAIL basic_send_hold got %b, want 1", Sending_Enable);
    end
    check_drained("basic");
  endtask

  task automatic test_done_sending();
    Done_Sending = 1'b1;
    tick();
    Done_Sending = 1'b0;
    tests++;
    if (Sending_Enable !== 1'b0 || Busy !== 1'b0 || Sample_Ready !== 1'b0) begin
      fails++;
      $display("FAIL done_idle got send=%b busy=%b rdy=%b, want 0 0 0",
               Sending_Enable, Busy, Sample_Ready);
    end
  endtask

  task automatic test_max_t();
    start_run(64'd1);
    for (int i = 0; i < 7; i++) begin
      push(3 + i, 64'h100 + 64'(i));  sample(1'b1, 64'h100 + 64'(i));
      push(10 + i, 64'h200 + 64'(i)); sample(1'b0, 64'h200 + 64'(i));
    end
    sample(1'b1, 64'hDEAD);
    tests++;
    if (Error !== 1'b1 || Sample_Ready !== 1'b0 || RAM_Write_Enable !== 1'b0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL max_t got err=%b rdy=%b we=%b busy=%b, want 1 0 0 0",
               Error, Sample_Ready, RAM_Write_Enable, Busy);
    end
    tick();
    check_drained("max_t");
  endtask

  task automatic test_kind_mismatch();
    start_run(64'd2);
    tests++;
    if (Error !== 1'b0) begin
      fails++;
      $display("FAIL kind_err_clear got %b, want 0", Error);
    end
    push(3, 64'h55); sample(1'b1, 64'h55);
    sample(1'b1, 64'h66);
    tests++;
    if (Error !== 1'b1 || RAM_Write_Enable !== 1'b0) begin
      fails++;
      $display("FAIL kind_mismatch got err=%b we=%b, want 1 0", Error, RAM_Write_Enable);
    end
    tick();
    check_drained("kind");
  endtask

  task automatic test_bad_finish();
    start_run(64'd2);
    push(3, 64'h1); sample(1'b1, 64'h1);
    push(10, 64'h2); sample(1'b0, 64'h2);
    Finish = 1'b1;
    tick();
    Finish = 1'b0;
    tests++;
    if (Error !== 1'b1 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_group_finish got err=%b busy=%b, want 1 0", Error, Busy);
    end
    start_run(64'd0);
    tests++;
    if (Error !== 1'b1 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_num_x got err=%b busy=%b, want 1 0", Error, Busy);
    end
    tick();
    check_drained("bad_finish");
  endtask

  task automatic test_finish_wins();
    start_run(64'd1);
    push(3, 64'h11); sample(1'b1, 64'h11);
    push(10, 64'h22); sample(1'b0, 64'h22);
    Finish       = 1'b1;
    Sample_Valid = 1'b1;
    Sample_Is_T  = 1'b1;
    Sample_Data  = 64'h99;
    #1;
    tests++;
    if (Sample_Ready !== 1'b0) begin
      fails++;
      $display("FAIL finish_ready got %b, want 0", Sample_Ready);
    end
    push(1, 64'd1);
    push(2, 64'd1);
    tick();
    Finish       = 1'b0;
    Sample_Valid = 1'b0;
    Sample_Is_T  = 1'b0;
    tick();
    tick();
    tests++;
    if (Sending_Enable !== 1'b1 || Error !== 1'b0) begin
      fails++;
      $display("FAIL finish_wins got send=%b err=%b, want 1 0", Sending_Enable, Error);
    end
    check_drained("finish_wins");
    test_done_sending();
  endtask

  task automatic test_x_overflow();
    start_run(64'd8200);
    push(3, 64'h7); sample(1'b1, 64'h7);
    for (int i = 0; i < 8182; i++) begin
      push(10 + i, 64'(i));
      sample(1'b0, 64'(i));
    end
    sample(1'b0, 64'hFFFF);
    tests++;
    if (Error !== 1'b1 || RAM_Write_Enable !== 1'b0) begin
      fails++;
      $display("FAIL x_overflow got err=%b we=%b, want 1 0", Error, RAM_Write_Enable);
    end
    check_drained("x_overflow");
  endtask

  task automatic test_async_reset();
    start_run(64'd2);
    push(3, 64'hAA); sample(1'b1, 64'hAA);
    Sample_Valid = 1'b1;
    Sample_Is_T  = 1'b0;
    Sample_Data  = 64'hBB;
    push(10, 64'hBB);
    tick();
    Sample_Valid = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    tests++;
    if ({Busy, Error, Sending_Enable, RAM_Write_Enable, Sample_Ready} !== 5'b0
        || RAM_Address !== 13'd0 || RAM_Data !== 64'd0) begin
      fails++;
      $display("FAIL async_reset got busy=%b we=%b addr=%0d data=%0h, want all 0",
               Busy, RAM_Write_Enable, RAM_Address, RAM_Data);
    end
    #2;
    RST_N = 1'b1;
    tick();
    tests++;
    if (RAM_Write_Enable !== 1'b0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got we=%b busy=%b, want 0 0", RAM_Write_Enable, Busy);
    end
    start_run(64'd3);
    push(3, 64'hCC); sample(1'b1, 64'hCC);
    push(10, 64'hCD); sample(1'b0, 64'hCD);
    check_drained("async_reset");
  endtask

  initial begin
    RST_N        = 1'b0;
    Start        = 1'b0;
    Num_X        = '0;
    Sample_Valid = 1'b0;
    Sample_Is_T  = 1'b0;
    Sample_Data  = '0;
    Finish       = 1'b0;
    Done_Sending = 1'b0;
    #12;
    RST_N = 1'b1;
    tick();
    test_reset();
    test_basic_run();
    test_done_sending();
    test_max_t();
    test_kind_mismatch();
    test_bad_finish();
    test_finish_wins();
    test_x_overflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/results_writer.md
RESULTS_WRITER -- requirements
Module: results_writer

Interface
REQ-001 The module SHALL have parameter ADDRESS_WIDTH, default 13, giving the RAM address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 64, giving the sample and RAM word width.
REQ-003 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port Start, input, 1 bit: a one-cycle pulse that opens a run.
REQ-006 The module SHALL have port Num_X, input, DATA_WIDTH bits: X values per T, sampled on an accepted Start.
REQ-007 The module SHALL have ports Sample_Valid (input, 1), Sample_Ready (output, 1), Sample_Is_T (input, 1) and Sample_Data (input, DATA_WIDTH): the solver result stream.
REQ-008 The module SHALL have port Finish, input, 1 bit: a one-cycle pulse that closes a run.
REQ-009 The module SHALL have ports RAM_Address (output, ADDRESS_WIDTH), RAM_Data (output, DATA_WIDTH) and RAM_Write_Enable (output, 1): the RAM write port.
REQ-010 The module SHALL have port Sending_Enable, output, 1 bit: level request to the downstream results sender.
REQ-011 The module SHALL have port Done_Sending, input, 1 bit: completion from the downstream sender.
REQ-012 The module SHALL have ports Busy (output, 1) and Error (output, 1).

Function
REQ-013 The FSM SHALL have states IDLE, COLLECT, HDR_T, HDR_X, SEND and ERR; Busy SHALL be 1 in every state except IDLE and ERR.
REQ-014 In IDLE or ERR, Start SHALL latch Num_X, clear num_t, set the T pointer to 3, set the X pointer to 10, set expect-T, clear Error, and go to COLLECT; Num_X=0 SHALL instead go to ERR.
REQ-015 Start SHALL be ignored in COLLECT, HDR_T, HDR_X and SEND.
REQ-016 Sample_Ready SHALL equal (state==COLLECT) && !Finish; a sample SHALL be accepted only when Sample_Valid && Sample_Ready.
REQ-017 An accepted T (expect-T, Is_T=1) SHALL write to the T pointer, increment the T pointer and num_t, and switch to expect-X with x_idx=0.
REQ-018 An accepted X (expect-X, Is_T=0) SHALL write to the X pointer, then increment the X pointer and x_idx; at x_idx==Num_X-1 the module SHALL return to expect-T.
REQ-019 The X address SHALL be a running pointer equal to 10 + t*Num_X + x; no multiplier SHALL be used.
REQ-020 RAM outputs SHALL be registered: a sample accepted at edge k SHALL drive Address, Data and Write_Enable=1 for exactly the cycle after edge k; otherwise Write_Enable SHALL be 0.
REQ-021 A kind mismatch (Is_T differs from the expected kind) SHALL go to ERR with no write.
REQ-022 An 8th T (num_t==7), or an X pointer that would exceed 2^ADDRESS_WIDTH-1, SHALL go to ERR with no write.
REQ-023 Finish in COLLECT SHALL go to HDR_T when expect-T and num_t>=1; otherwise it SHALL go to ERR.
REQ-024 Finish asserted together with Sample_Valid SHALL win, and the sample SHALL not be accepted.
REQ-025 HDR_T SHALL write zero-extended num_t to address 1, then go to HDR_X.
REQ-026 HDR_X SHALL write Num_X to address 2, then go to SEND.
REQ-027 Sending_Enable SHALL be registered and high exactly while in SEND; Done_Sending=1 in SEND SHALL go to IDLE, and SHALL be ignored in all other states.
REQ-028 ERR SHALL hold Error=1 and Sample_Ready=0, with no writes, until a Start or reset.

Reset
REQ-029 RST_N low SHALL asynchronously force IDLE and set every output and counter to 0, independent of CLK.
REQ-030 Reset mid-run SHALL abort with no further writes; RAM contents are undefined until the next run.

Structure
REQ-031 Package results_layout_pkg SHALL hold NUMBER_OF_T_ADDRESS=1, NUMBER_OF_X_ADDRESS=2, STARTING_OF_T_ADDRESS=3, STARTING_OF_X_ADDRESS=10, MAX_T=7 and the state enum, shared with the results sender.
REQ-032 One sub-module, results_addr_gen, SHALL hold the T/X pointers, x_idx, num_t and the overflow flags; the FSM and output registers SHALL stay in the top level.

Verification
REQ-033 Start with Num_X=2, then stream T0,X00,X01,T1,X10,X11 and Finish -> writes to addresses 3,10,11,4,12,13, then addr1=2 and addr2=2, then Sending_Enable=1.
REQ-034 In SEND, assert Done_Sending for one cycle -> Sending_Enable=0 and IDLE on the next cycle.
REQ-035 With Num_X=1, stream 7 T/X pairs then an 8th T -> Error=1, Sample_Ready=0, no write to address 10.
REQ-036 Stream T0 then another T -> Error=1 and no second write.
REQ-037 Assert Finish and Sample_Valid in the same cycle after a complete group -> the sample is not accepted and header writes follow.
REQ-038 Drop RST_N low between CLK edges mid-COLLECT -> outputs are 0 immediately; a following Start with Num_X=3 writes its first T at address 3.
